// File: rtl/usb_bus_pkg.sv
// ---------------------------------------------------------------------------
// usb_bus_pkg : shared types and constants for the USB bus sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CMD  = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_ABORT = 1;
    localparam int STAT_INT   = 2;
    localparam int STAT_SCS   = 3;

    // Counter reload value for a phase lasting n clocks.
    function automatic logic [3:0] phase_load(input int n);
        return 4'(n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_bus_sequencer_sync2.sv
// ---------------------------------------------------------------------------
// sync2 : two-flop synchroniser, resets to 1 (idle level of an active-low line)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/usb_bus_sequencer.sv
// ---------------------------------------------------------------------------
// usb_bus_sequencer : Avalon-MM slave stretching accesses to the USB chip bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_bus_sequencer
    import usb_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        scs_en,
    input  logic        usb_int_n,
    output logic        usb_cs_n,
    output logic        usb_rd_n,
    output logic        usb_wr_n,
    output logic        usb_a0,
    output logic [7:0]  usb_data_o,
    output logic        usb_data_oe,
    input  logic [7:0]  usb_data_i
);

    localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;
    logic        a0_q, a0_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdbuf_q, rdbuf_d;
    logic        abort_q, abort_d;
    logic [31:0] readdata_q, readdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        a0_o_q, a0_o_d;
    logic [7:0]  data_o_q, data_o_d;
    logic        oe_q, oe_d;

    logic        w_req;
    logic        w_rd;
    logic        w_bus_addr;
    logic        w_int_sync_n;
    logic        w_in_cycle;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_req      = chipselect & (~read_n | ~write_n);
    assign w_rd       = ~read_n;
    assign w_bus_addr = (address == ADDR_DATA) || (address == ADDR_CMD);
    assign w_unused   = ^writedata[31:8];

    sync2 u_int_sync (
        .clk (clk),
        .rst (reset),
        .d_i (usb_int_n),
        .q_o (w_int_sync_n)
    );

    always_comb begin
        w_status             = '0;
        w_status[STAT_BUSY]  = 1'b0;
        w_status[STAT_ABORT] = abort_q;
        w_status[STAT_INT]   = ~w_int_sync_n;
        w_status[STAT_SCS]   = scs_en;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; one down-counter times every bus phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_bus_addr && scs_en) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, read sampling, status flag and readdata
    always_comb begin
        is_rd_d    = is_rd_q;
        a0_d       = a0_q;
        wdata_d    = wdata_q;
        rdbuf_d    = rdbuf_q;
        abort_d    = abort_q;
        readdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_bus_addr && scs_en) begin
                        is_rd_d = w_rd;
                        a0_d    = address[0];
                        wdata_d = writedata[7:0];
                    end else begin
                        if (w_bus_addr) begin
                            abort_d = 1'b1;
                        end
                        if (address == ADDR_STAT) begin
                            if (w_rd) begin
                                readdata_d = w_status;
                            end else if (writedata[STAT_ABORT]) begin
                                abort_d = 1'b0;
                            end
                        end
                    end
                end
            end
            ST_STROBE: begin
                if ((cnt_q == 4'd0) && is_rd_q) begin
                    rdbuf_d = usb_data_i;
                end
            end
            ST_HOLD: begin
                if ((cnt_q == 4'd0) && is_rd_q) begin
                    readdata_d = {24'd0, rdbuf_q};
                end
            end
            default: ;
        endcase
    end

    // Bus outputs are decoded from the next state so they register cleanly
    always_comb begin
        w_in_cycle = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                     (state_d == ST_HOLD);
        cs_n_d     = ~w_in_cycle;
        rd_n_d     = ~((state_d == ST_STROBE) && is_rd_d);
        wr_n_d     = ~((state_d == ST_STROBE) && !is_rd_d);
        oe_d       = w_in_cycle && !is_rd_d;
        data_o_d   = oe_d ? wdata_d : 8'd0;
        a0_o_d     = w_in_cycle ? a0_d : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_rd_q    <= 1'b0;
            a0_q       <= 1'b0;
            wdata_q    <= '0;
            rdbuf_q    <= '0;
            abort_q    <= 1'b0;
            readdata_q <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a0_o_q     <= 1'b0;
            data_o_q   <= '0;
            oe_q       <= 1'b0;
        end else begin
            is_rd_q    <= is_rd_d;
            a0_q       <= a0_d;
            wdata_q    <= wdata_d;
            rdbuf_q    <= rdbuf_d;
            abort_q    <= abort_d;
            readdata_q <= readdata_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a0_o_q     <= a0_o_d;
            data_o_q   <= data_o_d;
            oe_q       <= oe_d;
        end
    end

    assign waitrequest = w_req && (state_q != ST_DONE);
    assign readdata    = readdata_q;
    assign usb_cs_n    = cs_n_q;
    assign usb_rd_n    = rd_n_q;
    assign usb_wr_n    = wr_n_q;
    assign usb_a0      = a0_o_q;
    assign usb_data_o  = data_o_q;
    assign usb_data_oe = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usb_bus_sequencer : scoreboard bench for usb_bus_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read_n, write_n;
    logic [31:0] writedata;
    logic        scs_en, usb_int_n;
    logic        cs_a, cs_b;
    logic        sel;
    logic [7:0]  chip_val;
    logic [7:0]  usb_data_i;

    logic [31:0] rdat_a, rdat_b;
    logic        wait_a, wait_b, ucs_a, ucs_b, urd_a, urd_b, uwr_a, uwr_b;
    logic        ua0_a, ua0_b, uoe_a, uoe_b;
    logic [7:0]  udo_a, udo_b;

    logic [31:0] m_rdat;
    logic        m_wait, m_cs_n, m_rd_n, m_wr_n, m_a0, m_oe, m_req;
    logic [7:0]  m_do;

    always #5 clk = ~clk;

    usb_bus_sequencer u_dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdat_a), .waitrequest(wait_a), .scs_en(scs_en),
        .usb_int_n(usb_int_n), .usb_cs_n(ucs_a), .usb_rd_n(urd_a),
        .usb_wr_n(uwr_a), .usb_a0(ua0_a), .usb_data_o(udo_a),
        .usb_data_oe(uoe_a), .usb_data_i(usb_data_i)
    );

    usb_bus_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdat_b), .waitrequest(wait_b), .scs_en(scs_en),
        .usb_int_n(usb_int_n), .usb_cs_n(ucs_b), .usb_rd_n(urd_b),
        .usb_wr_n(uwr_b), .usb_a0(ua0_b), .usb_data_o(udo_b),
        .usb_data_oe(uoe_b), .usb_data_i(usb_data_i)
    );

    assign m_rdat = sel ? rdat_b : rdat_a;
    assign m_wait = sel ? wait_b : wait_a;
    assign m_cs_n = sel ? ucs_b  : ucs_a;
    assign m_rd_n = sel ? urd_b  : urd_a;
    assign m_wr_n = sel ? uwr_b  : uwr_a;
    assign m_a0   = sel ? ua0_b  : ua0_a;
    assign m_oe   = sel ? uoe_b  : uoe_a;
    assign m_do   = sel ? udo_b  : udo_a;
    assign m_req  = (sel ? cs_b : cs_a) & (~read_n | ~write_n);

    // Chip model: drives its read value only while the strobe is low
    assign usb_data_i = m_rd_n ? 8'h00 : chip_val;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cnt = 0;
    bit   mon_en = 1'b0;
    bit   done_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT releases waitrequest
    always @(negedge clk) begin
        if (!mon_en || !m_req) begin
            mon_cnt = 0;
        end else if (m_wait) begin
            mon_cnt++;
        end else begin
            if (sb_q.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_latency"}, 32'(mon_cnt), 32'(e.lat));
                if (e.chk_data) chk({e.name, "_readdata"}, m_rdat, e.data);
            end
            done_seen = 1'b1;
            mon_cnt   = 0;
        end
    end

    logic [15:0] cs_m, rd_m, wr_m, oe_m, a0_m, dat_m;

    task automatic access(input bit s, input logic [1:0] addr, input bit is_rd,
                          input logic [7:0] wd, input logic [31:0] exp_data,
                          input int exp_lat, input string nm);
        exp_t e;
        e.data = exp_data; e.chk_data = is_rd; e.lat = exp_lat; e.name = nm;
        cs_m = '0; rd_m = '0; wr_m = '0; oe_m = '0; a0_m = '0; dat_m = '0;
        @(posedge clk); #1;
        sel = s;
        sb_q.push_back(e);
        done_seen = 1'b0;
        address   = addr;
        writedata = {24'd0, wd};
        read_n    = ~is_rd;
        write_n   = is_rd;
        if (s) cs_b = 1'b1; else cs_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 16) begin
                cs_m[c]  = ~m_cs_n;
                rd_m[c]  = ~m_rd_n;
                wr_m[c]  = ~m_wr_n;
                oe_m[c]  = m_oe;
                a0_m[c]  = ~m_cs_n & m_a0;
                dat_m[c] = m_oe && (m_do == wd);
            end
            #1;
            if (done_seen) break;
        end
        if (!done_seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            sb_q.delete();
        end
        @(posedge clk); #1;
        cs_a = 1'b0; cs_b = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = '0; read_n = 1'b1; write_n = 1'b1;
        writedata = '0; scs_en = 1'b1; usb_int_n = 1'b1;
        cs_a = 1'b0; cs_b = 1'b0; sel = 1'b0; chip_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {28'd0, ucs_a, urd_a, uwr_a, ua0_a}, 32'hE);
        chk("rst_oe", {31'd0, uoe_a}, 32'd0);
        chk("rst_data_o", {24'd0, udo_a}, 32'd0);
        chk("rst_readdata", rdat_a, 32'd0);
        chk("rst_wait", {31'd0, wait_a}, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        access(1'b0, 2'd0, 1'b0, 8'hA5, 32'd0, 9, "wr_a5");
        chk("wr_a5_cs", cs_m, 16'h01FE);
        chk("wr_a5_wr", wr_m, 16'h0078);
        chk("wr_a5_rd", rd_m, 16'h0000);
        chk("wr_a5_oe", oe_m, 16'h01FE);
        chk("wr_a5_data", dat_m, 16'h01FE);
        chk("wr_a5_a0", a0_m, 16'h0000);

        chip_val = 8'h3C;
        access(1'b0, 2'd1, 1'b1, 8'h00, 32'h0000003C, 9, "rd_cmd");
        chk("rd_cmd_cs", cs_m, 16'h01FE);
        chk("rd_cmd_rd", rd_m, 16'h0078);
        chk("rd_cmd_wr", wr_m, 16'h0000);
        chk("rd_cmd_oe", oe_m, 16'h0000);
        chk("rd_cmd_a0", a0_m, 16'h01FE);

        scs_en = 1'b0;
        access(1'b0, 2'd0, 1'b0, 8'h11, 32'd0, 1, "wr_noscs");
        chk("wr_noscs_bus", {16'd0, cs_m | rd_m | wr_m | oe_m}, 32'd0);
        access(1'b0, 2'd2, 1'b1, 8'h00, 32'h2, 1, "stat_abort");
        scs_en = 1'b1;
        access(1'b0, 2'd2, 1'b0, 8'h02, 32'd0, 1, "stat_clr");
        access(1'b0, 2'd2, 1'b1, 8'h00, 32'h8, 1, "stat_clean");
        access(1'b0, 2'd3, 1'b0, 8'hFF, 32'd0, 1, "wr_rsvd");
        access(1'b0, 2'd3, 1'b1, 8'h00, 32'd0, 1, "rd_rsvd");

        @(posedge clk); #1;
        usb_int_n = 1'b0;
        @(posedge clk);
        access(1'b0, 2'd2, 1'b1, 8'h00, 32'hC, 1, "stat_int");
        usb_int_n = 1'b1;

        // Reset in the middle of a write strobe
        mon_en = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; address = 2'd0; writedata = 32'h5A;
        write_n = 1'b0; cs_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_wr", {31'd0, uwr_a}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ctl", {28'd0, ucs_a, urd_a, uwr_a, uoe_a}, 32'hE);
        cs_a = 1'b0; write_n = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        access(1'b0, 2'd1, 1'b0, 8'h96, 32'd0, 9, "wr_post_rst");
        chk("wr_post_rst_cs", cs_m, 16'h01FE);
        chk("wr_post_rst_wr", wr_m, 16'h0078);
        chk("wr_post_rst_data", dat_m, 16'h01FE);
        chk("wr_post_rst_a0", a0_m, 16'h01FE);

        chip_val = 8'h5E;
        access(1'b1, 2'd0, 1'b1, 8'h00, 32'h0000005E, 4, "rd_fast");
        chk("rd_fast_cs", cs_m, 16'h000E);
        chk("rd_fast_rd", rd_m, 16'h0004);
        chk("rd_fast_wr_oe", {16'd0, wr_m | oe_m}, 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_bus_sequencer.md
# usb_bus_sequencer

Avalon-MM slave that runs timed read/write cycles on the 8-bit parallel bus of the external USB controller chip. It sits directly downstream of the USB slave chip-select PIO: that PIO's single-bit output arrives here as `scs_en` and gates whether bus cycles reach the chip. Software accesses the controller's data and command ports through this block, which stretches each access to the chip's setup/strobe/hold timing using `waitrequest`.

## Interface
- `SETUP_CYC`, 2: clocks of address/CS valid before strobe; legal range 1..15.
- `STROBE_CYC`, 4: clocks of nRD/nWR low; legal range 1..15.
- `HOLD_CYC`, 2: clocks of address/CS/data held after strobe; legal range 1..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous and active-high.
- `address` in 2: 0 = chip data port (A0=0), 1 = chip command port (A0=1), 2 = status register, 3 = reserved.
- `chipselect` in 1: Avalon select.
- `read_n` in 1: Avalon read, active-low.
- `write_n` in 1: Avalon write, active-low.
- `writedata` in 32: bits [7:0] are used.
- `readdata` out 32: zero-extended result.
- `waitrequest` out 1: stall.
- `scs_en` in 1: chip enable from the SCS PIO.
- `usb_int_n` in 1: chip interrupt, asynchronous.
- `usb_cs_n`, `usb_rd_n`, `usb_wr_n`, `usb_a0` out 1 each: chip bus controls.
- `usb_data_o` out 8, `usb_data_oe` out 1, `usb_data_i` in 8: split tri-state bus, with the pad at top level.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. A single 4-bit down-counter times SETUP, STROBE and HOLD.
- IDLE, on `chipselect` with `read_n`=0 or `write_n`=0:
  - address 0/1 with `scs_en`=1: latch the direction, A0=address[0] and `writedata[7:0]`, then go to SETUP.
  - address 2/3, or `scs_en`=0: go straight to DONE with no bus cycle. When `scs_en`=0 for address 0/1, also set the sticky `abort` flag.
- If `read_n` and `write_n` are both low, the access is treated as a read.
- SETUP: `usb_cs_n`=0 and `usb_a0` valid. For writes, `usb_data_oe`=1 and `usb_data_o` holds the latched data.
- STROBE: `usb_rd_n` or `usb_wr_n` is 0. On a read, `usb_data_i` is sampled into an 8-bit register on the clock edge that ends the last STROBE cycle.
- HOLD: strobe is back to 1; CS, A0 and data are unchanged.
- DONE: one cycle with `waitrequest`=0 and `readdata` valid, then return to IDLE.
- Status register (address 2) readdata bits:
  - [0] busy: always 0 when seen by the host.
  - [1] `abort` sticky flag: cleared by a write to address 2 with bit1=1.
  - [2] `int_pending`: synchronised, inverted `usb_int_n`.
  - [3] `scs_en`.
  - All other bits 0.
- Address 3 reads 0; writes to it are ignored.
- `usb_int_n` passes through a 2-FF synchroniser before use.
- Reset: FSM goes to IDLE; `usb_cs_n`/`usb_rd_n`/`usb_wr_n`=1, `usb_a0`=0, `usb_data_oe`=0, `usb_data_o`=0, `readdata`=0, `abort`=0, synchroniser=1s. A reset asserted mid-cycle takes effect immediately and aborts the cycle.
- If `scs_en` falls mid-cycle, the cycle completes normally; `scs_en` is sampled only in IDLE.

## Timing
- `waitrequest` = `chipselect` & (~`read_n` | ~`write_n`) & (state != DONE), computed combinationally.
- Bus-cycle latency: with request seen in IDLE at cycle 0, SETUP occupies cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, and DONE S+T+H+1. With defaults, `waitrequest` is low in cycle 9.
- Non-bus accesses: DONE in cycle 1.
- `usb_rd_n` and `usb_wr_n` are never low together and never low outside STROBE.
- `usb_data_oe` is never 1 during a read cycle.
- All bus outputs are registered, so they are glitch-free.
- `readdata` is registered and valid only in DONE.

## Structure
- Shared package `usb_bus_pkg` holds:
  - state enum;
  - address constants ADDR_DATA=0, ADDR_CMD=1, ADDR_STAT=2;
  - status bit indices.
- One sub-module, `sync2`, is the 2-FF synchroniser for `usb_int_n`, with reset value 1.
- Everything else is flat.

## Test plan
- Write 0xA5 to address 0 with `scs_en`=1 and defaults:
  - `usb_cs_n` low for cycles 1–8;
  - `usb_wr_n` low exactly cycles 3–6;
  - `usb_a0`=0;
  - `usb_data_o`=0xA5 with `usb_data_oe`=1 for cycles 1–8;
  - `waitrequest` low in cycle 9.
- Read address 1 with the chip model driving 0x3C during STROBE:
  - `usb_a0`=1 and `usb_rd_n` low cycles 3–6;
  - `usb_data_oe`=0;
  - `readdata`=0x0000003C in DONE.
- Write to address 0 with `scs_en`=0:
  - no CS/strobe activity;
  - DONE in cycle 1;
  - status read returns bit1=1 and bit3=0;
  - a write of 0x2 to address 2 then clears bit1.
- Hold `usb_int_n` low: status bit2 reads 1 no later than 3 cycles after the assertion.
- Assert `reset` during STROBE of a write:
  - all bus controls return to 1 asynchronously;
  - `usb_data_oe`=0;
  - the next access runs normally.
- Parameters SETUP=1, STROBE=1, HOLD=1 on a read: `usb_rd_n` low in cycle 2 only, DONE in cycle 4.
